load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage between the execute stage (ALU address and store data) and the byte-wide data memory.
- Accepts one load or store request per handshake and sequences it as one byte access per cycle on the memory port, little-endian.
- For loads, assembles the returned bytes and sign- or zero-extends them to 32 bits.
- Replaces direct word-wide stores so every store goes through the same byte-serial path.

Parameters:
- MEM_BYTES, 128: number of addressable bytes; every access must lie entirely inside 0..MEM_BYTES-1.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous reset, active low
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address from the ALU
- req_wdata  in  32  store data
- resp_valid  out  1  one-cycle pulse, request finished
- resp_rdata  out  32  load result (0 for stores and errors)
- resp_err  out  1  valid only with resp_valid
- mem_dir  out  32  memory byte address
- mem_wen  out  1  memory byte write enable
- mem_wdata  out  8  memory write byte
- mem_rdata  in  8  memory read byte, combinational from mem_dir

Behaviour:
- Clocking and reset: one clock domain; reset_n is asynchronous, active-low.
- Reset values:
  - state IDLE; req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_dir=0, mem_wen=0, mem_wdata=0.
  - Internal byte index and load buffer are 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch addr, size, we, wdata and unsigned; set index=0 and n = bytes-1 (0, 1 or 3).
  - Error check, done in 33-bit arithmetic so address wrap cannot hide an error: req_size==11, or addr+n >= MEM_BYTES.
  - Error -> go to RESP with err=1. Otherwise -> go to ACCESS.
- ACCESS:
  - Drive mem_dir = addr+index and mem_wen = we.
  - mem_wdata = wdata[8*index+7 : 8*index].
  - Loads: capture mem_rdata into buffer byte [index] at the clock edge.
  - If index==n, go to RESP; otherwise index+1.
- RESP:
  - resp_valid=1 for exactly one cycle, then return to IDLE.
  - resp_rdata for loads: buffer extended from bit 7 (byte) or bit 15 (half) according to req_unsigned; a word load passes the buffer through unchanged.
  - resp_rdata is 0 for stores and for errors.
- Outside ACCESS: mem_wen=0, mem_dir=0, mem_wdata=0.
- req_ready=0 in ACCESS and RESP; requests presented then are not accepted and must be held by the source.
- Latency from the accept edge:
  - resp_valid is high in cycle bytes+1 (byte 2, half 3, word 5).
  - An error response is high in cycle 1.
  - Throughput is one request per bytes+2 cycles.
- Error responses never assert mem_wen.
- Reset mid-operation:
  - Aborts immediately; no further mem_wen, no resp_valid.
  - Bytes already written stay in memory.
  - The unit is back in IDLE with req_ready=1 once reset_n rises.
- Misaligned half/word accesses are performed byte-serially, subject to the optional feature below.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a half with addr[0]!=0, or a word with addr[1:0]!=0, is an error: RESP with err=1 in cycle 1, no memory access.
- Not defined: misaligned accesses complete normally, byte by byte.

Test Plan:
- Store word 0xA1B2C3D4 at 0x10 -> mem_wen=1 in cycles 1-4 with (mem_dir, mem_wdata) = (0x10,D4), (0x11,C3), (0x12,B2), (0x13,A1); resp_valid=1, err=0 in cycle 5.
- Then signed byte load from 0x13 -> resp_rdata=0xFFFFFFA1 in cycle 2; the same load unsigned -> 0x000000A1.
- Then signed half load from 0x12 -> 0xFFFFA1B2 in cycle 3; word load from 0x10 -> 0xA1B2C3D4 in cycle 5.
- Word load at 126 with MEM_BYTES=128 -> resp_valid=1, resp_err=1, resp_rdata=0 in cycle 1, mem_wen never 1; req_size=11 behaves the same.
- Drop reset_n after the 2nd byte of a word store to 0x20 -> only 0x20 and 0x21 written, no resp_valid; req_ready=1 after reset_n rises.
- Signed half load from 0x11 (memory still holding the first scenario's data) -> with LSU_MISALIGN_TRAP_EN: err=1 in cycle 1; without: 0xFFFFB2C3 in cycle 3.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Interface for the load/store unit.
// Carries the request/response handshake from the execute stage and the
// byte-wide data memory port.
//   slave  : LSU view (takes requests, drives responses and the memory port)
//   master : environment view (execute stage plus data memory)
// Signals:
//   req_valid/req_ready, req_we, req_size, req_unsigned, req_addr, req_wdata
//   resp_valid, resp_rdata, resp_err
//   mem_dir, mem_wen, mem_wdata, mem_rdata
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_dir;
  logic        mem_wen;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_dir, mem_wen, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_dir, mem_wen, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between execute and a byte-wide data
// memory. Each accepted load/store is sequenced one byte per cycle,
// little-endian; loads are reassembled and sign/zero-extended to 32 bits.
// Ports:
//   clock    : system clock, rising edge
//   reset_n  : asynchronous reset, active low
//   bus      : load_store_unit_if.slave (request/response + memory port)
// Parameters:
//   MEM_BYTES : addressable bytes; an access must lie fully in 0..MEM_BYTES-1
// Build option:
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned half/word accesses are
//   rejected with an error response instead of being done byte by byte.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic              clock,
  input  logic              reset_n,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t      state_q, state_d;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rbuf_q;
  logic [1:0]  size_q;
  logic [1:0]  index_q;
  logic [1:0]  last_q;
  logic        we_q;
  logic        uns_q;
  logic        err_q;

  logic        accept;
  logic [1:0]  req_last;
  logic [32:0] req_end;
  logic        misalign;
  logic        req_err;
  logic [31:0] load_ext;

  // Request decode and range check. The end address is formed in 33 bits so
  // an access wrapping past 0xFFFFFFFF is still caught as out of range.
  always_comb begin
    req_last = 2'd0;
    case (bus.req_size)
      2'b00:   req_last = 2'd0;
      2'b01:   req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
    req_end = {1'b0, bus.req_addr} + {31'b0, req_last};
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
               ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    req_err = (bus.req_size == 2'b11) || (req_end >= 33'(MEM_BYTES)) || misalign;
  end

  assign accept = bus.req_valid && (state_q == IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = req_err ? RESP : ACCESS;
      ACCESS:  if (index_q == last_q) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      size_q  <= '0;
      index_q <= '0;
      last_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      rbuf_q  <= '0;
      size_q  <= bus.req_size;
      index_q <= '0;
      last_q  <= req_last;
      we_q    <= bus.req_we;
      uns_q   <= bus.req_unsigned;
      err_q   <= req_err;
    end else if (state_q == ACCESS) begin
      if (!we_q) begin
        rbuf_q[{index_q, 3'b000} +: 8] <= bus.mem_rdata;
      end
      if (index_q != last_q) begin
        index_q <= index_q + 2'd1;
      end
    end
  end

  // Extension uses the top bit of the accessed width; a word passes through.
  always_comb begin
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & rbuf_q[7]}},  rbuf_q[7:0]};
      2'b01:   load_ext = {{16{~uns_q & rbuf_q[15]}}, rbuf_q[15:0]};
      default: load_ext = rbuf_q;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.resp_err   = (state_q == RESP) && err_q;
    bus.resp_rdata = ((state_q == RESP) && !err_q && !we_q) ? load_ext : '0;
    bus.mem_wen    = 1'b0;
    bus.mem_dir    = '0;
    bus.mem_wdata  = '0;
    if (state_q == ACCESS) begin
      bus.mem_wen   = we_q;
      bus.mem_dir   = addr_q + {30'b0, index_q};
      bus.mem_wdata = wdata_q[{index_q, 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a 128-byte memory model.
module tb_load_store_unit;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic mem_clear = 1'b1;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:127];
  logic [31:0] wr_dir  [0:7];
  logic [7:0]  wr_data [0:7];
  int          wr_cyc  [0:7];

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(128)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  assign bus.mem_rdata = (bus.mem_dir < 32'd128) ? mem[bus.mem_dir[6:0]] : 8'h00;

  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
    end else if (bus.mem_wen && (bus.mem_dir < 32'd128)) begin
      mem[bus.mem_dir[6:0]] <= bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents a request in IDLE; returns at the sample point of cycle 1.
  task automatic start_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clock);
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    check("ready_at_request", 32'(bus.req_ready), 32'd1);
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int cyc, output logic [31:0] rdata,
                         output logic err, output int nwr);
    cyc   = -1;
    nwr   = 0;
    rdata = 32'hDEAD_BEEF;
    err   = 1'bx;
    start_req(we, size, uns, addr, wdata);
    for (int c = 1; c <= 12; c++) begin
      if (bus.mem_wen) begin
        if (nwr < 8) begin
          wr_dir[nwr]  = bus.mem_dir;
          wr_data[nwr] = bus.mem_wdata;
          wr_cyc[nwr]  = c;
        end
        nwr++;
      end
      if (bus.resp_valid) begin
        cyc   = c;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        break;
      end
      @(posedge clock);
      #1;
    end
    if (cyc < 0) begin
      check("resp_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clock);
      #1;
      check("resp_pulse_end", 32'(bus.resp_valid), 32'd0);
    end
  endtask

  task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] exp_data,
                         input int exp_cyc);
    int cyc, nwr;
    logic [31:0] rdata;
    logic err;
    run_req(1'b0, size, uns, addr, 32'h0, cyc, rdata, err, nwr);
    check({tag, "_cyc"},  32'(cyc), 32'(exp_cyc));
    check({tag, "_data"}, rdata, exp_data);
    check({tag, "_err"},  32'(err), 32'd0);
    check({tag, "_nwr"},  32'(nwr), 32'd0);
  endtask

  task automatic do_err(input string tag, input logic we, input logic [1:0] size,
                        input logic [31:0] addr);
    int cyc, nwr;
    logic [31:0] rdata;
    logic err;
    run_req(we, size, 1'b0, addr, 32'hCAFE_F00D, cyc, rdata, err, nwr);
    check({tag, "_cyc"},  32'(cyc), 32'd1);
    check({tag, "_data"}, rdata, 32'd0);
    check({tag, "_err"},  32'(err), 32'd1);
    check({tag, "_nwr"},  32'(nwr), 32'd0);
  endtask

  task automatic do_store_word(input string tag, input logic [31:0] addr,
                               input logic [31:0] wdata);
    int cyc, nwr;
    logic [31:0] rdata;
    logic err;
    logic [31:0] w;
    run_req(1'b1, 2'b10, 1'b0, addr, wdata, cyc, rdata, err, nwr);
    check({tag, "_cyc"},  32'(cyc), 32'd5);
    check({tag, "_err"},  32'(err), 32'd0);
    check({tag, "_data"}, rdata, 32'd0);
    check({tag, "_nwr"},  32'(nwr), 32'd4);
    w = wdata;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_wr_dir"},  wr_dir[i], addr + 32'(i));
      check({tag, "_wr_byte"}, 32'(wr_data[i]), 32'(w[7:0]));
      check({tag, "_wr_cyc"},  32'(wr_cyc[i]), 32'(i + 1));
      w = w >> 8;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen_wen, seen_resp;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_ready",      32'(bus.req_ready),  32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err",   32'(bus.resp_err),   32'd0);
    check("rst_resp_rdata", bus.resp_rdata,      32'd0);
    check("rst_mem_dir",    bus.mem_dir,         32'd0);
    check("rst_mem_wen",    32'(bus.mem_wen),    32'd0);
    check("rst_mem_wdata",  32'(bus.mem_wdata),  32'd0);
    @(negedge clock);
    reset_n   = 1'b1;
    mem_clear = 1'b0;
    @(posedge clock);
    #1;

    // Word store, then readback in every width.
    do_store_word("st_w10", 32'h10, 32'hA1B2_C3D4);
    check("mem_13", 32'(mem[8'h13]), 32'hA1);
    do_load("ld_b13_s", 2'b00, 1'b0, 32'h13, 32'hFFFF_FFA1, 2);
    do_load("ld_b13_u", 2'b00, 1'b1, 32'h13, 32'h0000_00A1, 2);
    do_load("ld_b10_s", 2'b00, 1'b0, 32'h10, 32'hFFFF_FFD4, 2);
    do_load("ld_h12_s", 2'b01, 1'b0, 32'h12, 32'hFFFF_A1B2, 3);
    do_load("ld_h12_u", 2'b01, 1'b1, 32'h12, 32'h0000_A1B2, 3);
    do_load("ld_w10",   2'b10, 1'b0, 32'h10, 32'hA1B2_C3D4, 5);

    // Range and size errors.
    do_err("err_w126",  1'b0, 2'b10, 32'd126);
    do_err("err_sz11",  1'b0, 2'b11, 32'h10);
    do_err("err_st126", 1'b1, 2'b10, 32'd126);
    do_err("err_h127",  1'b0, 2'b01, 32'd127);
    do_err("err_wrap",  1'b0, 2'b10, 32'hFFFF_FFFE);
    check("mem_126_untouched", 32'(mem[126]), 32'h00);

    // Last legal word and byte.
    do_store_word("st_w124", 32'd124, 32'h1122_3344);
    do_load("ld_w124",  2'b10, 1'b0, 32'd124, 32'h1122_3344, 5);
    do_load("ld_b127",  2'b00, 1'b0, 32'd127, 32'h0000_0011, 2);

    // Reset after the second byte of a word store.
    start_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h5566_7788);
    check("rst_mid_ready_busy", 32'(bus.req_ready), 32'd0);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_wen_async", 32'(bus.mem_wen), 32'd0);
    seen_wen  = 0;
    seen_resp = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      if (bus.mem_wen)    seen_wen++;
      if (bus.resp_valid) seen_resp++;
    end
    check("rst_mid_no_wen",  32'(seen_wen),  32'd0);
    check("rst_mid_no_resp", 32'(seen_resp), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mid_m20", 32'(mem[8'h20]), 32'h88);
    check("rst_mid_m21", 32'(mem[8'h21]), 32'h77);
    check("rst_mid_m22", 32'(mem[8'h22]), 32'h00);
    check("rst_mid_m23", 32'(mem[8'h23]), 32'h00);
    do_load("ld_after_rst", 2'b10, 1'b0, 32'h10, 32'hA1B2_C3D4, 5);

    // Misaligned accesses.
`ifdef LSU_MISALIGN_TRAP_EN
    do_err("mis_h11", 1'b0, 2'b01, 32'h11);
    do_err("mis_w11", 1'b0, 2'b10, 32'h11);
`else
    do_load("mis_h11", 2'b01, 1'b0, 32'h11, 32'hFFFF_B2C3, 3);
    do_load("mis_w11", 2'b10, 1'b0, 32'h11, 32'h00A1_B2C3, 5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
